// File: rtl/reg_dump_display.sv
// reg_dump_display
// Debug reader for the register file's ReadReg/ReadRegData port. It picks a
// register index, either auto-scanning or stepped by a push-button, and shows
// one 16-bit half of that register as four hex digits on a multiplexed
// 7-segment display. It sits beside the pipeline at board level.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high
//   auto_scan    1 = auto-increment the index every DWELL_CYCLES, 0 = manual
//   step         raw push-button (asynchronous); advances the index in manual mode
//   half_sel     0 = show bits [15:0], 1 = show bits [31:16]
//   ReadReg      register index to the debug read port
//   ReadRegData  debug read data (combinational from ReadReg)
//   cur_index    copy of the index, for LEDs
//   an           digit anodes, active low, an[0] = rightmost digit
//   seg          segment cathodes, active low, seg[0]=a ... seg[6]=g
module reg_dump_display #(
  parameter int DWELL_CYCLES   = 100000000,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_scan,
  input  logic        step,
  input  logic        half_sel,
  output logic [4:0]  ReadReg,
  input  logic [31:0] ReadRegData,
  output logic [4:0]  cur_index,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DW_W = (DWELL_CYCLES   > 1) ? $clog2(DWELL_CYCLES)   : 1;
  localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [DW_W-1:0] DWELL_LAST   = DW_W'(DWELL_CYCLES - 1);
  localparam logic [RF_W-1:0] REFRESH_LAST = RF_W'(REFRESH_CYCLES - 1);

  // Hex digit to active-low segments, g..a order.
  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0:    f_hex7 = 7'b1000000;
      4'h1:    f_hex7 = 7'b1111001;
      4'h2:    f_hex7 = 7'b0100100;
      4'h3:    f_hex7 = 7'b0110000;
      4'h4:    f_hex7 = 7'b0011001;
      4'h5:    f_hex7 = 7'b0010010;
      4'h6:    f_hex7 = 7'b0000010;
      4'h7:    f_hex7 = 7'b1111000;
      4'h8:    f_hex7 = 7'b0000000;
      4'h9:    f_hex7 = 7'b0010000;
      4'hA:    f_hex7 = 7'b0001000;
      4'hB:    f_hex7 = 7'b0000011;
      4'hC:    f_hex7 = 7'b1000110;
      4'hD:    f_hex7 = 7'b0100001;
      4'hE:    f_hex7 = 7'b0000110;
      default: f_hex7 = 7'b0001110;
    endcase
  endfunction

  logic            r_s1, r_s2, r_sp;
  logic [DW_W-1:0] r_dwell;
  logic [4:0]      r_idx;
  logic [RF_W-1:0] r_refresh;
  logic [1:0]      r_dp;
  logic [31:0]     r_snap;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  logic            w_stp_pulse;
  logic            w_dwell_tc;
  logic            w_refresh_tc;
  logic            w_inc;
  logic [15:0]     w_half;
  logic [3:0]      w_nib;

  // Button synchronizer and edge detect. Loading ones on reset means a button
  // held through reset release looks like "already pressed" and gives no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_sp <= 1'b1;
    end else begin
      r_s1 <= step;
      r_s2 <= r_s1;
      r_sp <= r_s2;
    end
  end

  assign w_stp_pulse = r_s2 & ~r_sp;

  // Index selection: dwell timer in auto mode, button pulse in manual mode.
  assign w_dwell_tc = (r_dwell == DWELL_LAST);
  assign w_inc      = auto_scan ? w_dwell_tc : w_stp_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell <= '0;
    end else if (!auto_scan || w_dwell_tc) begin
      // Held at 0 in manual mode so entering auto mode gives a full dwell.
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + DW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= 5'd0;
    end else if (w_inc) begin
      r_idx <= r_idx + 5'd1;
    end
  end

  // Digit multiplexing and per-frame snapshot.
  assign w_refresh_tc = (r_refresh == REFRESH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_dp      <= 2'd0;
    end else if (w_refresh_tc) begin
      r_refresh <= '0;
      r_dp      <= r_dp + 2'd1;
    end else begin
      r_refresh <= r_refresh + RF_W'(1);
    end
  end

  // Snapshot only when the pointer wraps back to digit 0, so one frame never
  // mixes digits from two different register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= 32'd0;
    end else if (w_refresh_tc && (r_dp == 2'd3)) begin
      r_snap <= ReadRegData;
    end
  end

  assign w_half = half_sel ? r_snap[31:16] : r_snap[15:0];
  assign w_nib  = w_half[{r_dp, 2'b00} +: 4];

  // Output register: anode and segments move together, one cycle behind dp.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
    end else begin
      r_an  <= ~(4'b0001 << r_dp);
      r_seg <= f_hex7(w_nib);
    end
  end

  assign ReadReg   = r_idx;
  assign cur_index = r_idx;
  assign an        = r_an;
  assign seg       = r_seg;

endmodule

// File: tb/tb_reg_dump_display.sv
// Testbench for reg_dump_display with DWELL_CYCLES=8, REFRESH_CYCLES=2.
// Stimulus pushes expected values tagged with the cycle they are due; a
// monitor on the falling edge pops and compares them.
module tb_reg_dump_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        auto_scan = 1'b0;
  logic        step = 1'b0;
  logic        half_sel = 1'b0;
  logic [31:0] ReadRegData = 32'd0;
  logic [4:0]  ReadReg;
  logic [4:0]  cur_index;
  logic [3:0]  an;
  logic [6:0]  seg;

  reg_dump_display #(
    .DWELL_CYCLES  (8),
    .REFRESH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .auto_scan  (auto_scan),
    .step       (step),
    .half_sel   (half_sel),
    .ReadReg    (ReadReg),
    .ReadRegData(ReadRegData),
    .cur_index  (cur_index),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;   // 0 ReadReg, 1 cur_index, 2 an, 3 seg
    logic [6:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;
  logic drained = 1'b0;

  // Hand-computed glyphs and anode patterns.
  localparam logic [6:0] G_0 = 7'b1000000;
  localparam logic [6:0] G_F = 7'b0001110;
  logic [6:0] g_lo [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000}; // D C b A
  logic [6:0] g_hi [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}; // 4 3 2 1
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int k, input int kind, input logic [6:0] val,
                           input string name);
    exp_t e;
    e.cyc  = cyc + k;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_idx(input int k, input logic [4:0] v, input string name);
    expect_at(k, 0, {2'b00, v}, {name, "_ReadReg"});
    expect_at(k, 1, {2'b00, v}, {name, "_cur_index"});
  endtask

  // Monitor
  exp_t       m_e;
  logic [6:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        0:       m_act = {2'b00, ReadReg};
        1:       m_act = {2'b00, cur_index};
        2:       m_act = {3'b000, an};
        default: m_act = seg;
      endcase
      checks++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        errors++;
        $display("FAIL %s at cyc %0d (due %0d): got %b, want %b",
                 m_e.name, cyc, m_e.cyc, m_act, m_e.val);
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
    end
  end

  initial begin
    int d;
    int fr;
    logic [6:0] sx;

    // Reset for 3 cycles, then release straight into auto-scan.
    tick(3);
    reset     = 1'b0;
    auto_scan = 1'b1;
    expect_idx(0, 5'd0, "rst");
    expect_at(0, 2, 7'(4'b1110), "rst_an");
    expect_at(0, 3, G_0, "rst_seg");
    expect_idx(1, 5'd0, "post_rst");
    expect_at(1, 2, 7'(4'b1110), "post_rst_an");
    expect_at(1, 3, G_0, "post_rst_seg");
    expect_idx(7, 5'd0, "auto_c7");
    expect_idx(8, 5'd1, "auto_c8");
    expect_idx(248, 5'd31, "auto_c248");
    expect_idx(256, 5'd0, "auto_wrap");
    tick(256);

    // Manual mode: long press gives exactly one increment, on the 3rd edge.
    auto_scan = 1'b0;
    step      = 1'b1;
    expect_idx(2, 5'd0, "press1_e2");
    expect_idx(3, 5'd1, "press1_e3");
    expect_idx(20, 5'd1, "press1_held");
    tick(20);
    step = 1'b0;
    tick(5);
    step = 1'b1;
    expect_idx(2, 5'd1, "press2_e2");
    expect_idx(3, 5'd2, "press2_e3");
    tick(10);
    step = 1'b0;
    tick(5);

    // Press while in auto mode is ignored; auto entry starts a full dwell.
    auto_scan = 1'b1;
    step      = 1'b1;
    expect_idx(7, 5'd2, "auto_press_c7");
    expect_idx(8, 5'd3, "auto_press_c8");
    tick(8);
    auto_scan = 1'b0;
    step      = 1'b0;
    expect_idx(5, 5'd3, "release_no_pulse");
    tick(5);

    // Digit mux, snapshot, half select and mid-frame data change.
    ReadRegData = 32'h1234ABCD;
    half_sel    = 1'b0;
    reset       = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_idx(0, 5'd0, "mux_rst");
    for (int e = 1; e <= 40; e++) begin
      d  = ((e - 1) / 2) % 4;
      fr = (e - 1) / 8;
      case (fr)
        0:       sx = G_0;
        1:       sx = g_lo[d];
        2:       sx = g_hi[d];
        3:       sx = g_lo[d];
        default: sx = G_F;
      endcase
      expect_at(e, 2, {3'b000, an_tab[d]}, $sformatf("mux_an_e%0d", e));
      expect_at(e, 3, sx, $sformatf("mux_seg_e%0d", e));
    end
    tick(16);
    half_sel = 1'b1;
    tick(8);
    half_sel = 1'b0;
    tick(2);
    ReadRegData = 32'hFFFFFFFF;   // dp is 1 here
    tick(14);

    // Step held through a reset asserted mid-dwell at idx=5.
    auto_scan = 1'b1;
    expect_idx(40, 5'd5, "dwell_idx5");
    expect_idx(43, 5'd5, "dwell_idx5_mid");
    expect_idx(47, 5'd5, "dwell_idx5_late");
    tick(43);
    step = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2);
    reset     = 1'b0;
    auto_scan = 1'b0;
    expect_idx(0, 5'd0, "held_rst");
    expect_at(0, 2, 7'(4'b1110), "held_rst_an");
    expect_at(0, 3, G_0, "held_rst_seg");
    expect_idx(3, 5'd0, "held_no_pulse_e3");
    expect_idx(10, 5'd0, "held_no_pulse_e10");
    tick(10);

    tick(2);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
